// File: rtl/stream_serializer.sv
// stream_serializer: accepts one RATIO*PAYLOAD_BITS word over a val/ready
// upstream link and emits it as RATIO consecutive PAYLOAD_BITS beats on a
// val/ready downstream link, with no bubble between words while downstream
// stays ready.
//
// Optional feature macro: SERIALIZER_LAST_EN
//   defined   -> adds last_out (final beat of the word) and beat_idx (beat number)
//   undefined -> those ports do not exist; everything else is unchanged
module stream_serializer #(
    parameter int PAYLOAD_BITS = 32,
    parameter int RATIO        = 4,
    parameter bit LSB_FIRST    = 1'b1,
    localparam int CNT_W       = ($clog2(RATIO) < 1) ? 1 : $clog2(RATIO),
    localparam int WORD_W      = RATIO * PAYLOAD_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    val_in,
    output logic                    ready_upward,
    input  logic [WORD_W-1:0]       din,
    output logic                    val_out,
    input  logic                    ready_downward,
    output logic [PAYLOAD_BITS-1:0] dout
`ifdef SERIALIZER_LAST_EN
    ,
    output logic                    last_out,
    output logic [CNT_W-1:0]        beat_idx
`endif
);

    // A serializer with fewer than two beats per word is meaningless.
    if (RATIO < 2) begin : g_bad_ratio
        $error("stream_serializer: RATIO must be at least 2");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [WORD_W-1:0]       sreg;
    logic [CNT_W-1:0]        cnt;

    logic                    in_send;
    logic                    on_last;
    logic                    up_xfer;
    logic                    dn_xfer;
    logic [PAYLOAD_BITS-1:0] beat_slice;
    logic [WORD_W-1:0]       sreg_shifted;

    assign in_send = (state == ST_SEND);
    assign on_last = in_send && (cnt == LAST_CNT);
    assign up_xfer = val_in && ready_upward;
    assign dn_xfer = val_out && ready_downward;

    // The beat on the wire is always the slice at the "leaving" end of sreg;
    // shifting moves the next slice into that position.
    if (LSB_FIRST) begin : g_lsb_first
        assign beat_slice   = sreg[PAYLOAD_BITS-1:0];
        assign sreg_shifted = sreg >> PAYLOAD_BITS;
    end else begin : g_msb_first
        assign beat_slice   = sreg[WORD_W-1 -: PAYLOAD_BITS];
        assign sreg_shifted = sreg << PAYLOAD_BITS;
    end

    // State register; asynchronous reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave SEND only when the last beat goes out and no new
    // word is loaded in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (val_in) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (dn_xfer && (cnt == LAST_CNT) && !val_in) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register and beat counter: a load wins over a shift, which is
    // what lets the last beat of one word and the load of the next coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (up_xfer) begin
            sreg <= din;
            cnt  <= '0;
        end else if (dn_xfer) begin
            sreg <= sreg_shifted;
            cnt  <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    // Outputs: all derived from registered state, except ready_upward which
    // also opens combinationally on the accepted last beat.
    always_comb begin
        val_out      = in_send;
        ready_upward = (state == ST_IDLE) || (on_last && ready_downward);
        dout         = in_send ? beat_slice : '0;
    end

`ifdef SERIALIZER_LAST_EN
    // Beat position flags, stable while stalled because cnt is held.
    always_comb begin
        last_out = on_last;
        beat_idx = cnt;
    end
`endif

endmodule
